// File: rtl/sdram_access_ctrl.sv
// Post-init SDRAM access controller: single-word writes, 8-word burst reads, auto-precharge, periodic refresh.
// Write occupies 2+T_RCD+T_WRP cycles and a read 2+T_RCD+CAS_LAT+8; oready is low whenever busy or a refresh is pending.
module sdram_access_ctrl #(
    parameter int REF_INTERVAL = 780,
    parameter int T_RCD        = 2,
    parameter int T_RC         = 7,
    parameter int T_WRP        = 4,
    parameter int CAS_LAT      = 2
) (
    input  logic        iclk,
    input  logic        ireset_n,
    output logic        oinit_req,
    output logic        oinit_enb,
    input  logic        iinit_done,
    input  logic        ireq,
    input  logic        iwr,
    input  logic [24:0] iaddr,
    input  logic [15:0] iwdata,
    output logic        oready,
    output logic [15:0] ordata,
    output logic        ordvalid,
    output logic        ordlast,
    output wire         DRAM_CLK,
    output wire         DRAM_CKE,
    output wire         DRAM_CS_N,
    output wire         DRAM_RAS_N,
    output wire         DRAM_CAS_N,
    output wire         DRAM_WE_N,
    output wire  [12:0] DRAM_ADDR,
    output wire  [1:0]  DRAM_BA,
    output wire         DRAM_UDQM,
    output wire         DRAM_LDQM,
    inout  wire  [15:0] DRAM_DQ
);

    typedef enum logic [3:0] {
        S_WAIT_INIT, S_IDLE, S_REF, S_REF_WAIT, S_ACT,
        S_RCD_WAIT, S_WR, S_WR_WAIT, S_RD, S_RD_DATA
    } state_t;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam int RW = $clog2(REF_INTERVAL + 1);
    localparam int TW = 8;

    state_t         state_q, state_d;
    logic [TW-1:0]  tmr_q;
    logic [RW-1:0]  ref_cnt_q;
    logic           ref_pending_q;
    logic           wr_q;
    logic [24:0]    addr_q;
    logic [15:0]    wdata_q;
    logic           own, dq_oe, rd_cap;
    logic [3:0]     cmd;
    logic [12:0]    addr_o;
    logic [1:0]     ba_o, dqm_o;

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q <= S_WAIT_INIT;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= (state_d != state_q) ? '0 : tmr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_INIT: if (iinit_done) state_d = S_IDLE;
            S_IDLE: begin
                if (ref_pending_q)  state_d = S_REF;
                else if (ireq)      state_d = S_ACT;
            end
            S_REF:      state_d = (T_RC > 1) ? S_REF_WAIT : S_IDLE;
            S_REF_WAIT: if (tmr_q == TW'(T_RC - 2)) state_d = S_IDLE;
            S_ACT:      state_d = (T_RCD > 1) ? S_RCD_WAIT : (wr_q ? S_WR : S_RD);
            S_RCD_WAIT: if (tmr_q == TW'(T_RCD - 2)) state_d = wr_q ? S_WR : S_RD;
            S_WR:       state_d = S_WR_WAIT;
            S_WR_WAIT:  if (tmr_q == TW'(T_WRP - 1)) state_d = S_IDLE;
            S_RD:       state_d = S_RD_DATA;
            S_RD_DATA:  if (tmr_q == TW'(CAS_LAT + 7)) state_d = S_IDLE;
            default:    state_d = S_WAIT_INIT;
        endcase
    end

    always_comb begin
        own       = 1'b1;
        oinit_req = 1'b0;
        oinit_enb = 1'b0;
        oready    = 1'b0;
        cmd       = CMD_NOP;
        addr_o    = '0;
        ba_o      = '0;
        dqm_o     = 2'b11;
        dq_oe     = 1'b0;
        case (state_q)
            S_WAIT_INIT: begin
                own       = 1'b0;
                oinit_req = 1'b1;
                oinit_enb = 1'b1;
            end
            S_IDLE: oready = !ref_pending_q;
            S_REF:  cmd = CMD_REF;
            S_ACT: begin
                cmd    = CMD_ACT;
                ba_o   = addr_q[24:23];
                addr_o = addr_q[22:10];
            end
            S_WR: begin
                cmd    = CMD_WRITE;
                ba_o   = addr_q[24:23];
                addr_o = {2'b00, 1'b1, addr_q[9:0]};
                dqm_o  = 2'b00;
                dq_oe  = 1'b1;
            end
            S_RD: begin
                cmd    = CMD_READ;
                ba_o   = addr_q[24:23];
                addr_o = {2'b00, 1'b1, addr_q[9:0]};
            end
            default: ;
        endcase
    end

    // A second expiry while a refresh is still pending simply keeps the flag set.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            ref_cnt_q     <= RW'(REF_INTERVAL);
            ref_pending_q <= 1'b0;
        end else if (state_q == S_WAIT_INIT) begin
            if (iinit_done) ref_cnt_q <= RW'(REF_INTERVAL);
        end else if (ref_cnt_q == '0) begin
            ref_cnt_q     <= RW'(REF_INTERVAL);
            ref_pending_q <= 1'b1;
        end else begin
            ref_cnt_q <= ref_cnt_q - 1'b1;
            if (state_q == S_REF) ref_pending_q <= 1'b0;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (ireq && oready) begin
            wr_q    <= iwr;
            addr_q  <= iaddr;
            wdata_q <= iwdata;
        end
    end

    // tmr_q counts from the cycle after READ, so the first word is on the bus when tmr_q == CAS_LAT-1.
    assign rd_cap = (state_q == S_RD_DATA) && (tmr_q >= TW'(CAS_LAT - 1))
                    && (tmr_q <= TW'(CAS_LAT + 6));

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            ordata   <= '0;
            ordvalid <= 1'b0;
            ordlast  <= 1'b0;
        end else begin
            ordvalid <= rd_cap;
            ordlast  <= rd_cap && (tmr_q == TW'(CAS_LAT + 6));
            if (rd_cap) ordata <= DRAM_DQ;
        end
    end

    assign DRAM_CLK   = own ? ~iclk     : 1'bz;
    assign DRAM_CKE   = own ? 1'b1      : 1'bz;
    assign DRAM_CS_N  = own ? cmd[3]    : 1'bz;
    assign DRAM_RAS_N = own ? cmd[2]    : 1'bz;
    assign DRAM_CAS_N = own ? cmd[1]    : 1'bz;
    assign DRAM_WE_N  = own ? cmd[0]    : 1'bz;
    assign DRAM_ADDR  = own ? addr_o    : 13'bz;
    assign DRAM_BA    = own ? ba_o      : 2'bz;
    assign DRAM_UDQM  = own ? dqm_o[1]  : 1'bz;
    assign DRAM_LDQM  = own ? dqm_o[0]  : 1'bz;
    assign DRAM_DQ    = dq_oe ? wdata_q : 16'bz;

endmodule

// File: tb/tb_sdram_access_ctrl.sv
// Bench for sdram_access_ctrl: directed write table, burst-read model, refresh spacing, refresh/request collision, reset mid-read.
module tb_sdram_access_ctrl;

    localparam int CL = 2;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100, REF = 4'b0001;

    logic        iclk = 1'b0;
    logic        ireset_n, iinit_done, ireq, iwr;
    logic [24:0] iaddr;
    logic [15:0] iwdata;
    wire         oinit_req, oinit_enb, oready, ordvalid, ordlast;
    wire  [15:0] ordata;
    wire         dram_clk, dram_cke, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
    wire  [12:0] dram_addr;
    wire  [1:0]  dram_ba;
    wire         dram_udqm, dram_ldqm;
    wire  [15:0] dram_dq;

    // Pulls make an undriven pin visible: CS_N is always driven 0 when owned, CKE/UDQM idle at 1.
    pullup   (dram_cs_n);
    pulldown (dram_cke);
    pulldown (dram_udqm);

    sdram_access_ctrl dut (
        .iclk(iclk), .ireset_n(ireset_n), .oinit_req(oinit_req), .oinit_enb(oinit_enb),
        .iinit_done(iinit_done), .ireq(ireq), .iwr(iwr), .iaddr(iaddr), .iwdata(iwdata),
        .oready(oready), .ordata(ordata), .ordvalid(ordvalid), .ordlast(ordlast),
        .DRAM_CLK(dram_clk), .DRAM_CKE(dram_cke), .DRAM_CS_N(dram_cs_n),
        .DRAM_RAS_N(dram_ras_n), .DRAM_CAS_N(dram_cas_n), .DRAM_WE_N(dram_we_n),
        .DRAM_ADDR(dram_addr), .DRAM_BA(dram_ba), .DRAM_UDQM(dram_udqm),
        .DRAM_LDQM(dram_ldqm), .DRAM_DQ(dram_dq)
    );

    always #5 iclk = ~iclk;

    wire [3:0] cmd = {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n};

    // SDRAM read model: READ is latched on the falling iclk edge (DRAM_CLK rising); word k
    // is driven from the falling edge CL+k cycles later, in sequential wrap order.
    logic        dq_en = 1'b0;
    logic [15:0] dq_drv = 16'h0;
    int          rd_beat = -1;
    logic [9:0]  rd_col = 10'h0;
    logic [2:0]  lo;
    assign dram_dq = dq_en ? dq_drv : 16'bz;

    always @(negedge iclk) begin
        if (cmd == RD) begin
            rd_beat = 0;
            rd_col  = dram_addr[9:0];
        end else if (rd_beat >= 0) begin
            rd_beat = rd_beat + 1;
        end
        if (rd_beat >= CL && rd_beat <= CL + 7) begin
            lo     = rd_col[2:0] + 3'(rd_beat - CL);
            dq_en  = 1'b1;
            dq_drv = 16'hB000 | {6'b0, rd_col[9:3], lo};
        end else begin
            dq_en = 1'b0;
            if (rd_beat > CL + 7) rd_beat = -1;
        end
    end

    typedef struct {
        logic        req;
        logic        wr;
        logic [24:0] addr;
        logic [15:0] wdata;
        logic [3:0]  cmd;
        logic        chk_ab;
        logic [1:0]  ba;
        logic [12:0] a;
        logic [1:0]  dqm;
        logic        chk_dq;
        logic [15:0] dq;
        logic        rdy;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo_b, input int hi_b);
        checks++;
        if (act < lo_b || act > hi_b) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo_b, hi_b);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt [9];
        logic [15:0] exp_rd [8];
        logic [24:0] wa, ra;
        logic [3:0]  seq [$];
        logic [15:0] wd [$];
        logic [3:0]  exp_seq [5];
        int          found, nrcd, nref, last, run, ref_in_run, f_cyc, n_acc, words, bad;
        logic        acc;

        wa = {2'b01, 13'h0ABC, 10'h012};
        vt[0] = '{1'b1, 1'b1, wa, 16'hBEEF, NOP, 1'b0, 2'b00, 13'h0,    2'b11, 1'b0, 16'h0,    1'b1};
        vt[1] = '{1'b0, 1'b0, 25'h0, 16'h0, ACT, 1'b1, 2'b01, 13'h0ABC, 2'b11, 1'b0, 16'h0,    1'b0};
        vt[2] = '{1'b0, 1'b0, 25'h0, 16'h0, NOP, 1'b0, 2'b00, 13'h0,    2'b11, 1'b0, 16'h0,    1'b0};
        vt[3] = '{1'b0, 1'b0, 25'h0, 16'h0, WR,  1'b1, 2'b01, 13'h0412, 2'b00, 1'b1, 16'hBEEF, 1'b0};
        vt[4] = '{1'b0, 1'b0, 25'h0, 16'h0, NOP, 1'b0, 2'b00, 13'h0,    2'b11, 1'b0, 16'h0,    1'b0};
        vt[5] = '{1'b0, 1'b0, 25'h0, 16'h0, NOP, 1'b0, 2'b00, 13'h0,    2'b11, 1'b0, 16'h0,    1'b0};
        vt[6] = '{1'b0, 1'b0, 25'h0, 16'h0, NOP, 1'b0, 2'b00, 13'h0,    2'b11, 1'b0, 16'h0,    1'b0};
        vt[7] = '{1'b0, 1'b0, 25'h0, 16'h0, NOP, 1'b0, 2'b00, 13'h0,    2'b11, 1'b0, 16'h0,    1'b0};
        vt[8] = '{1'b0, 1'b0, 25'h0, 16'h0, NOP, 1'b0, 2'b00, 13'h0,    2'b11, 1'b0, 16'h0,    1'b1};
        exp_rd = '{16'hB013, 16'hB014, 16'hB015, 16'hB016, 16'hB017, 16'hB010, 16'hB011, 16'hB012};
        exp_seq = '{ACT, WR, REF, ACT, WR};

        // Reset values
        ireset_n = 1'b0; iinit_done = 1'b0; ireq = 1'b0; iwr = 1'b0; iaddr = '0; iwdata = '0;
        #2;
        chk("rst_init_req", 32'(oinit_req), 32'd1);
        chk("rst_init_enb", 32'(oinit_enb), 32'd1);
        chk("rst_oready",   32'(oready),    32'd0);
        chk("rst_ordvalid", 32'(ordvalid),  32'd0);
        chk("rst_ordlast",  32'(ordlast),   32'd0);
        chk("rst_ordata",   32'(ordata),    32'd0);
        chk("rst_cs_z",     32'(dram_cs_n), 32'd1);
        chk("rst_cke_z",    32'(dram_cke),  32'd0);
        chk("rst_dqm_z",    32'(dram_udqm), 32'd0);
        #10 ireset_n = 1'b1;

        // Init handshake
        repeat (50) tick();
        chk("init_req_held", 32'(oinit_req), 32'd1);
        chk("init_enb_held", 32'(oinit_enb), 32'd1);
        chk("init_cs_z",     32'(dram_cs_n), 32'd1);
        chk("init_cke_z",    32'(dram_cke),  32'd0);
        chk("init_rdy_low",  32'(oready),    32'd0);
        iinit_done = 1'b1;
        tick();
        iinit_done = 1'b0;
        tick();
        chk("init_rdy",    32'(oready),    32'd1);
        chk("init_req_lo", 32'(oinit_req), 32'd0);
        chk("init_enb_lo", 32'(oinit_enb), 32'd0);
        chk("init_cke",    32'(dram_cke),  32'd1);
        chk("init_nop",    32'(cmd),       32'(NOP));

        // Write, table-driven one row per cycle
        for (int i = 0; i < 9; i++) begin
            ireq = vt[i].req; iwr = vt[i].wr; iaddr = vt[i].addr; iwdata = vt[i].wdata;
            chk($sformatf("wr%0d_cmd", i), 32'(cmd), 32'(vt[i].cmd));
            chk($sformatf("wr%0d_dqm", i), 32'({dram_udqm, dram_ldqm}), 32'(vt[i].dqm));
            chk($sformatf("wr%0d_rdy", i), 32'(oready), 32'(vt[i].rdy));
            if (vt[i].chk_ab) begin
                chk($sformatf("wr%0d_ba", i),   32'(dram_ba),   32'(vt[i].ba));
                chk($sformatf("wr%0d_addr", i), 32'(dram_addr), 32'(vt[i].a));
            end
            if (vt[i].chk_dq) chk($sformatf("wr%0d_dq", i), 32'(dram_dq), 32'(vt[i].dq));
            tick();
        end

        // Burst read from col 0x013
        ra = {2'b10, 13'h1234, 10'h013};
        ireq = 1'b1; iwr = 1'b0; iaddr = ra;
        chk("rd_accept_rdy", 32'(oready), 32'd1);
        tick();
        ireq = 1'b0;
        chk("rd_act",      32'(cmd),       32'(ACT));
        chk("rd_act_ba",   32'(dram_ba),   32'd2);
        chk("rd_act_row",  32'(dram_addr), 32'h1234);
        chk("rd_rdy_drop", 32'(oready),    32'd0);
        found = 0; nrcd = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            tick();
            nrcd++;
            if (cmd == RD) found = 1;
        end
        chk("rd_cmd_seen", 32'(found), 32'd1);
        chk("rd_trcd",     32'(nrcd),  32'd2);
        chk("rd_addr_ap",  32'(dram_addr), 32'h0413);
        chk("rd_ba",       32'(dram_ba),   32'd2);
        for (int j = 1; j <= 11; j++) begin
            tick();
            chk($sformatf("rd_vld_R+%0d", j),  32'(ordvalid), 32'(j >= 3 && j <= 10));
            chk($sformatf("rd_last_R+%0d", j), 32'(ordlast),  32'(j == 10));
            if (j >= 3 && j <= 10) chk($sformatf("rd_data%0d", j - 3), 32'(ordata), 32'(exp_rd[j - 3]));
            if (j == 11) chk("rd_idle_rdy", 32'(oready), 32'd1);
        end

        // Refresh spacing while idle
        nref = 0; last = -1; run = 0; ref_in_run = 0;
        for (int k = 0; k < 2600 && nref < 3; k++) begin
            tick();
            if (cmd == REF) begin
                chk("ref_rdy_low", 32'(oready), 32'd0);
                if (last >= 0) chk_range("ref_interval", cyc - last, 779, 781);
                last = cyc; nref++; ref_in_run = 1;
            end
            if (!oready) run++;
            else begin
                if (ref_in_run != 0) chk_range("ref_busy_len", run, 7, 8);
                run = 0; ref_in_run = 0;
            end
        end
        chk("ref_count", 32'(nref), 32'd3);
        f_cyc = cyc;

        // Collision: refresh expires during a write while the next request is held
        repeat (776) tick();
        chk("col_idle", 32'(oready), 32'd1);
        ireq = 1'b1; iwr = 1'b1; iaddr = {2'b11, 13'h0001, 10'h3FF}; iwdata = 16'h1111;
        n_acc = 0;
        for (int k = 0; k < 60; k++) begin
            acc = ireq && oready;
            if (cmd != NOP) seq.push_back(cmd);
            if (cmd == WR) wd.push_back(dram_dq);
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc == 1) iwdata = 16'h2222;
                else ireq = 1'b0;
            end
        end
        chk("col_accepts", 32'(n_acc),      32'd2);
        chk("col_ncmds",   32'(seq.size()), 32'd5);
        for (int i = 0; i < 5 && i < seq.size(); i++)
            chk($sformatf("col_cmd%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        if (wd.size() == 2) begin
            chk("col_wdata0", 32'(wd[0]), 32'h1111);
            chk("col_wdata1", 32'(wd[1]), 32'h2222);
        end else chk("col_nwrites", 32'(wd.size()), 32'd2);
        $display("refresh spacing reference cycle %0d", f_cyc);

        // Async reset during read data, after the fourth word
        ireq = 1'b1; iwr = 1'b0; iaddr = {2'b00, 13'h0005, 10'h020};
        chk("rst_rd_accept", 32'(oready), 32'd1);
        tick();
        ireq = 1'b0;
        words = 0;
        for (int k = 0; k < 30 && words < 4; k++) begin
            tick();
            if (ordvalid) words++;
        end
        chk("rst_rd_words", 32'(words), 32'd4);
        #2 ireset_n = 1'b0;
        #1;
        chk("mid_rst_vld",  32'(ordvalid),  32'd0);
        chk("mid_rst_last", 32'(ordlast),   32'd0);
        chk("mid_rst_data", 32'(ordata),    32'd0);
        chk("mid_rst_rdy",  32'(oready),    32'd0);
        chk("mid_rst_req",  32'(oinit_req), 32'd1);
        chk("mid_rst_enb",  32'(oinit_enb), 32'd1);
        chk("mid_rst_cs_z", 32'(dram_cs_n), 32'd1);
        chk("mid_rst_cke_z", 32'(dram_cke), 32'd0);
        tick();
        tick();
        #3 ireset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ordvalid || dram_cs_n == 1'b0) bad++;
        end
        chk("post_rst_quiet", 32'(bad),       32'd0);
        chk("post_rst_req",   32'(oinit_req), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_access_ctrl.md
# sdram_access_ctrl

Post-initialisation SDRAM access controller, directly downstream of the SDRAM initialisation FSM. It holds that FSM's request and enable high until its done flag rises, then takes ownership of the SDRAM pins. It serves single-word writes and 8-word burst reads through a ready/valid handshake, using auto-precharge on every access, and schedules periodic auto-refresh. The mode register programmed during init is fixed: CAS latency 2, sequential burst of 8, single-location write.

## Interface
Parameters:
- REF_INTERVAL, 780: cycles between auto-refreshes (7.8 us at 100 MHz)
- T_RCD, 2: cycles from ACTIVE to READ/WRITE
- T_RC, 7: cycles from REFRESH until the next command
- T_WRP, 4: cycles after WRITE+AP before the next command (tWR+tRP)
- CAS_LAT, 2: read latency in cycles; must match the mode register

Ports:
- iclk  in  1  system clock
- ireset_n  in  1  reset; one clock, asynchronous and active-low
- oinit_req  out  1  ireq to the init FSM
- oinit_enb  out  1  ienb to the init FSM (pin ownership)
- iinit_done  in  1  ofin from the init FSM
- ireq  in  1  access request
- iwr  in  1  1 = write, 0 = read (sampled with ireq)
- iaddr  in  25  {bank[24:23], row[22:10], col[9:0]}
- iwdata  in  16  write data
- oready  out  1  controller accepts a request this cycle
- ordata  out  16  read data word
- ordvalid  out  1  ordata valid
- ordlast  out  1  8th word of a burst
- DRAM_CLK, DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  out  1 each
- DRAM_ADDR  out  13;  DRAM_BA  out  2;  DRAM_UDQM, DRAM_LDQM  out  1 each
- DRAM_DQ  inout  16

## Operation
- Command encoding {CS,RAS,CAS,WE}:
  - NOP 0111, ACT 0011, READ 0101, WRITE 0100, REF 0001.
  - A10 = 1 on READ and WRITE selects auto-precharge.
- States: WAIT_INIT, IDLE, REF, REF_WAIT, ACT, RCD_WAIT, WR, WR_WAIT, RD, RD_DATA.
- WAIT_INIT:
  - oinit_req = oinit_enb = 1; every DRAM_* output of this block is Z.
  - Moves to IDLE on the cycle after iinit_done = 1.
  - Also clears oinit_req and oinit_enb, and loads the refresh counter with REF_INTERVAL.
- From IDLE onward this block drives the pins:
  - DRAM_CLK = ~iclk, CKE = 1.
  - DQM = 11 and DQ = Z except in WR.
- Refresh counter:
  - Decrements each cycle outside WAIT_INIT.
  - At 0 it sets ref_pending and reloads; a second expiry while pending is absorbed.
  - ref_pending is cleared when REF issues.
- IDLE:
  - ref_pending → REF, which issues REF for 1 cycle, then REF_WAIT for T_RC−1 cycles, then IDLE.
  - Otherwise oready = 1.
  - On ireq & oready, latch iwr, iaddr and iwdata, then go to ACT.
- ACT: issue ACT, BA = bank, ADDR = row; then RCD_WAIT for T_RCD−1 cycles.
- WR:
  - Issue WRITE, ADDR = {2'b00, 1'b1, col}, DQ = latched data, DQM = 00 for that cycle only.
  - Then WR_WAIT for T_WRP cycles, then IDLE.
- RD:
  - Issue READ with AP.
  - DQ is sampled on iclk rising edges starting CAS_LAT cycles after RD.
  - Captures 8 words in SDRAM sequential-burst order (wraps within the 8-aligned column block).
  - RD_DATA ends after the 8th capture, then IDLE.
- Requests are never queued; ireq while oready = 0 is ignored and the requester holds it.

## Timing
- Reset values (ireset_n = 0, immediate):
  - state WAIT_INIT; oinit_req = oinit_enb = 1.
  - oready, ordvalid, ordlast = 0; ordata = 0.
  - DRAM_* = Z; refresh counter = REF_INTERVAL; ref_pending = 0.
- Reset mid-access aborts the access immediately: no further commands, no read data.
- oready is combinational on state and ref_pending. It drops in the cycle after acceptance.
- Write, with acceptance in cycle A:
  - ACT in A+1, WRITE in A+1+T_RCD.
  - oready returns in A+2+T_RCD+T_WRP.
- Read, with READ issued in cycle R:
  - ordvalid = 1 in cycles R+CAS_LAT+1 … R+CAS_LAT+8, contiguous.
  - ordlast = 1 only in R+CAS_LAT+8.
  - IDLE in R+CAS_LAT+9.
- Refresh:
  - REF issues no later than 1 cycle after the current access finishes.
  - ref_pending and ireq in the same IDLE cycle: refresh wins and oready = 0.
- iinit_done is ignored after WAIT_INIT.

## Test plan
- Reset then init handshake: hold iinit_done = 0 for 50 cycles → oinit_req = oinit_enb = 1 and DQ = Z; raise it → oready = 1 two cycles later with CKE = 1 and NOP driven.
- Write: iaddr = {2'b01, 13'h0ABC, 10'h012}, iwdata = 16'hBEEF → ACT with BA = 01, ADDR = 0ABC; 2 cycles later WRITE with ADDR = 0x0412, DQ = BEEF, DQM = 00; oready back after T_WRP.
- Read: SDRAM model returns 8 words from col 0x013 → 8 contiguous ordvalid cycles starting R+3, data in wrap order 3,4,5,6,7,0,1,2; ordlast on the 8th.
- Refresh: idle for 2000 cycles → REF command every 780 cycles ±1; oready = 0 for T_RC cycles around each.
- Collision: hold ireq when the counter expires → REF issues first, then the request is accepted; no access is lost or duplicated.
- Async reset in RD_DATA after word 4 → ordvalid drops at once, pins go Z, oinit_req = 1.
